rle_bit_encoder: RTL

Run-length encoding engine between the HPS-facing input FIFO (fed 24-bit words through the `idata`/`fifo_in_write_req` PIOs) and the output FIFO (drained 8 bits at a time through the `odata`/`fifo_out_read_req` PIOs). It pops 24-bit words, serializes them MSB-first, and emits one 8-bit code per run: bit 7 is the run value and bits 6:0 are the run length, 1..127. Runs continue across word boundaries. The `rle_flush` PIO drives the flush request that closes the final partial run.

---
 rtl/rle_bit_encoder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rle_bit_encoder.sv
// Run-length encoder: pops IN_W-bit words, serializes them MSB-first and emits
// one {run_bit, run_len} code per run, with runs carried across word boundaries.
module rle_bit_encoder #(
   parameter int IN_W  = 24,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_empty,
   output logic             in_rd,
   output logic [CNT_W:0]   out_data,
   input  logic             out_full,
   output logic             out_wr,
   input  logic             flush,
   output logic             flush_done,
   output logic [1:0]       o_dbg_state
);

   // Handshake: a word is taken when in_rd=1 (only while in_empty=0); a code is
   // delivered when out_wr=1 (only while out_full=0); both are single-cycle strobes.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   localparam int              BC_W     = $clog2(IN_W);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(IN_W - 1);
   localparam logic [CNT_W-1:0] MAX_RUN = '1;

   state_t            r_state;
   logic [IN_W-1:0]   r_sreg;
   logic [BC_W-1:0]   r_bit_cnt;
   logic              r_run_bit;
   logic [CNT_W-1:0]  r_run_len;
   logic              r_flush_pend;
   logic              r_flush_done;

   logic              w_cur;
   logic              w_consume;
   logic              w_open_new;
   logic              w_in_rd;
   logic              w_out_wr;

   assign w_cur = r_sreg[IN_W-1];

   always_comb begin
      w_consume  = 1'b0;
      w_open_new = 1'b0;
      w_in_rd    = 1'b0;
      w_out_wr   = 1'b0;
      if (!reset) begin
         case (r_state)
            S_IDLE: w_in_rd = !in_empty;
            S_SHIFT: begin
               if (r_run_len == '0) begin
                  w_consume  = 1'b1;
                  w_open_new = 1'b1;
               end else if (w_cur == r_run_bit && r_run_len != MAX_RUN) begin
                  w_consume = 1'b1;
               end else if (!out_full) begin
                  // Close the current run and start a new one with this same bit.
                  w_out_wr   = 1'b1;
                  w_consume  = 1'b1;
                  w_open_new = 1'b1;
               end
            end
            S_FLUSH: w_out_wr = (r_run_len != '0) && !out_full;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_sreg       <= '0;
         r_bit_cnt    <= '0;
         r_run_bit    <= 1'b0;
         r_run_len    <= '0;
         r_flush_pend <= 1'b0;
         r_flush_done <= 1'b0;
      end else begin
         r_flush_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!in_empty) begin
                  r_sreg    <= in_data;
                  r_bit_cnt <= '0;
                  r_state   <= S_SHIFT;
               end else if (r_flush_pend) begin
                  r_state <= S_FLUSH;
               end
            end
            S_SHIFT: begin
               if (w_consume) begin
                  r_sreg    <= r_sreg << 1;
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (w_open_new) begin
                     r_run_bit <= w_cur;
                     r_run_len <= CNT_W'(1);
                  end else begin
                     r_run_len <= r_run_len + 1'b1;
                  end
                  if (r_bit_cnt == LAST_BIT) r_state <= S_IDLE;
               end
            end
            S_FLUSH: begin
               if (r_run_len == '0 || !out_full) begin
                  r_run_len    <= '0;
                  r_flush_pend <= 1'b0;
                  r_flush_done <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
         // A new request outranks the clear above, so it is never dropped.
         if (flush) r_flush_pend <= 1'b1;
      end
   end

   assign in_rd       = w_in_rd;
   assign out_wr      = w_out_wr;
   assign out_data    = w_out_wr ? {r_run_bit, r_run_len} : '0;
   assign flush_done  = r_flush_done;
   assign o_dbg_state = r_state;

endmodule
